// File: rtl/y86_fetch_exec_mem.sv
// Y86-64 fetch decode, execute ALU with condition codes, and 64-bit little-endian data memory.
// Instruction and data memories live here; pipeline registers and PC selection do not.
module y86_fetch_exec_mem #(
  parameter int unsigned IMEM_BYTES = 1024,
  parameter int unsigned DMEM_BYTES = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_we,
  input  logic [63:0] imem_waddr,
  input  logic [7:0]  imem_wdata,
  input  logic [63:0] f_pc,
  output logic [3:0]  f_icode,
  output logic [3:0]  f_ifun,
  output logic [3:0]  f_rA,
  output logic [3:0]  f_rB,
  output logic [63:0] f_valC,
  output logic [63:0] f_valP,
  output logic        instr_valid,
  output logic        imem_error,
  output logic        hlt,
  input  logic [3:0]  e_icode,
  input  logic [3:0]  e_ifun,
  input  logic [63:0] e_valA,
  input  logic [63:0] e_valB,
  input  logic [63:0] e_valC,
  input  logic        set_cc,
  output logic [63:0] e_valE,
  output logic        e_cnd,
  output logic        zf,
  output logic        sf,
  output logic        of,
  input  logic [3:0]  m_icode,
  input  logic [63:0] m_valA,
  input  logic [63:0] m_valE,
  input  logic [63:0] m_valP,
  output logic [63:0] m_valM,
  output logic        dmem_error
);

  localparam int unsigned IAW = $clog2(IMEM_BYTES);
  localparam int unsigned DAW = $clog2(DMEM_BYTES);

  logic [7:0] imem [IMEM_BYTES];
  logic [7:0] dmem [DMEM_BYTES];

  // ---------------- Fetch ----------------
  always_ff @(posedge clk) begin
    if (imem_we && (imem_waddr < 64'(IMEM_BYTES))) begin
      imem[imem_waddr[IAW-1:0]] <= imem_wdata;
    end
  end

  // Bytes past the end of imem read as zero; imem_error flags them separately.
  logic [7:0]  fb [10];
  logic [64:0] fb_addr [10];
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      fb_addr[k] = {1'b0, f_pc} + 65'(k);
      fb[k] = (fb_addr[k] < 65'(IMEM_BYTES)) ? imem[fb_addr[k][IAW-1:0]] : 8'h00;
    end
  end

  logic [3:0]  raw_icode, raw_ifun;
  logic [3:0]  ilen;
  logic        need_reg;
  logic [64:0] end_addr;

  assign raw_icode = fb[0][7:4];
  assign raw_ifun  = fb[0][3:0];

  always_comb begin
    ilen     = 4'd1;
    need_reg = 1'b0;
    f_valC   = '0;
    case (raw_icode)
      4'h2, 4'h6, 4'hA, 4'hB: begin
        ilen     = 4'd2;
        need_reg = 1'b1;
      end
      4'h3, 4'h4, 4'h5: begin
        ilen     = 4'd10;
        need_reg = 1'b1;
        f_valC   = {fb[9], fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2]};
      end
      4'h7, 4'h8: begin
        ilen   = 4'd9;
        f_valC = {fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2], fb[1]};
      end
      default: ilen = 4'd1;
    endcase
  end

  always_comb begin
    case (raw_icode)
      4'h6:       instr_valid = (raw_ifun <= 4'd3);
      4'h2, 4'h7: instr_valid = (raw_ifun <= 4'd6);
      4'hC, 4'hD, 4'hE, 4'hF: instr_valid = 1'b0;
      default:    instr_valid = (raw_ifun == 4'd0);
    endcase
  end

  assign end_addr   = {1'b0, f_pc} + 65'(ilen) - 65'd1;
  assign imem_error = (end_addr >= 65'(IMEM_BYTES));
  assign f_icode    = imem_error ? 4'h1 : raw_icode;
  assign f_ifun     = imem_error ? 4'h0 : raw_ifun;
  assign f_rA       = need_reg ? fb[1][7:4] : 4'hF;
  assign f_rB       = need_reg ? fb[1][3:0] : 4'hF;
  assign f_valP     = f_pc + 64'(ilen);
  assign hlt        = (raw_icode == 4'h0) && !imem_error;

  // ---------------- Execute ----------------
  logic of_new;

  always_comb begin
    e_valE = '0;
    of_new = 1'b0;
    case (e_icode)
      4'h2:       e_valE = e_valA;
      4'h3:       e_valE = e_valC;
      4'h4, 4'h5: e_valE = e_valB + e_valC;
      4'h6: begin
        case (e_ifun)
          4'h0: begin
            e_valE = e_valB + e_valA;
            of_new = (e_valA[63] == e_valB[63]) && (e_valE[63] != e_valA[63]);
          end
          4'h1: begin
            e_valE = e_valB - e_valA;
            of_new = (e_valA[63] != e_valB[63]) && (e_valE[63] != e_valB[63]);
          end
          4'h2:    e_valE = e_valB & e_valA;
          4'h3:    e_valE = e_valB ^ e_valA;
          default: e_valE = '0;
        endcase
      end
      4'h8, 4'hA: e_valE = e_valB - 64'd8;
      4'h9, 4'hB: e_valE = e_valB + 64'd8;
      default:    e_valE = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zf <= 1'b1;
      sf <= 1'b0;
      of <= 1'b0;
    end else if ((e_icode == 4'h6) && set_cc) begin
      zf <= (e_valE == 64'd0);
      sf <= e_valE[63];
      of <= of_new;
    end
  end

  always_comb begin
    e_cnd = 1'b0;
    if ((e_icode == 4'h2) || (e_icode == 4'h7)) begin
      case (e_ifun)
        4'h0:    e_cnd = 1'b1;
        4'h1:    e_cnd = (sf ^ of) | zf;
        4'h2:    e_cnd = sf ^ of;
        4'h3:    e_cnd = zf;
        4'h4:    e_cnd = ~zf;
        4'h5:    e_cnd = ~(sf ^ of);
        4'h6:    e_cnd = ~(sf ^ of) & ~zf;
        default: e_cnd = 1'b0;
      endcase
    end
  end

  // ---------------- Memory ----------------
  logic [63:0] m_addr, m_wdata;
  logic        m_access, m_rd, m_wr;

  always_comb begin
    m_addr   = m_valE;
    m_wdata  = m_valA;
    m_access = 1'b0;
    m_rd     = 1'b0;
    m_wr     = 1'b0;
    case (m_icode)
      4'h4, 4'hA: begin
        m_access = 1'b1;
        m_wr     = 1'b1;
      end
      4'h5: begin
        m_access = 1'b1;
        m_rd     = 1'b1;
      end
      4'h8: begin
        m_access = 1'b1;
        m_wr     = 1'b1;
        m_wdata  = m_valP;
      end
      4'h9, 4'hB: begin
        m_access = 1'b1;
        m_rd     = 1'b1;
        m_addr   = m_valA;
      end
      default: m_access = 1'b0;
    endcase
  end

  assign dmem_error = m_access && (({1'b0, m_addr} + 65'd7) >= 65'(DMEM_BYTES));

  always_comb begin
    m_valM = '0;
    if (m_rd && !dmem_error) begin
      for (int k = 0; k < 8; k++) begin
        m_valM[8*k +: 8] = dmem[m_addr[DAW-1:0] + DAW'(k)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (m_wr && !dmem_error) begin
      for (int k = 0; k < 8; k++) begin
        dmem[m_addr[DAW-1:0] + DAW'(k)] <= m_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_y86_fetch_exec_mem.sv
// Directed bench for y86_fetch_exec_mem: fetch and ALU tables, then flag, memory and reset sequences.
module tb_y86_fetch_exec_mem;

  localparam int unsigned IMEM_BYTES = 1024;
  localparam int unsigned DMEM_BYTES = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_we;
  logic [63:0] imem_waddr;
  logic [7:0]  imem_wdata;
  logic [63:0] f_pc;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic        instr_valid, imem_error, hlt;
  logic [3:0]  e_icode, e_ifun;
  logic [63:0] e_valA, e_valB, e_valC, e_valE;
  logic        set_cc, e_cnd, zf, sf, of;
  logic [3:0]  m_icode;
  logic [63:0] m_valA, m_valE, m_valP, m_valM;
  logic        dmem_error;

  int checks = 0;
  int failures = 0;

  y86_fetch_exec_mem #(.IMEM_BYTES(IMEM_BYTES), .DMEM_BYTES(DMEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .f_pc(f_pc), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP), .instr_valid(instr_valid),
    .imem_error(imem_error), .hlt(hlt),
    .e_icode(e_icode), .e_ifun(e_ifun), .e_valA(e_valA), .e_valB(e_valB),
    .e_valC(e_valC), .set_cc(set_cc), .e_valE(e_valE), .e_cnd(e_cnd),
    .zf(zf), .sf(sf), .of(of),
    .m_icode(m_icode), .m_valA(m_valA), .m_valE(m_valE), .m_valP(m_valP),
    .m_valM(m_valM), .dmem_error(dmem_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] addr, input logic [7:0] data);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    tick();
    imem_we    = 1'b0;
  endtask

  task automatic exec(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] c, input logic cc);
    e_icode = ic;
    e_ifun  = fn;
    e_valA  = a;
    e_valB  = b;
    e_valC  = c;
    set_cc  = cc;
    #1;
  endtask

  task automatic mem(input logic [3:0] ic, input logic [63:0] va, input logic [63:0] ve,
                     input logic [63:0] vp);
    m_icode = ic;
    m_valA  = va;
    m_valE  = ve;
    m_valP  = vp;
    #1;
  endtask

  task automatic flags(input string name, input logic ez, input logic es, input logic eo);
    chk({name, "_zf"}, 64'(zf), 64'(ez));
    chk({name, "_sf"}, 64'(sf), 64'(es));
    chk({name, "_of"}, 64'(of), 64'(eo));
  endtask

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        hlt;
  } fvec_t;

  typedef struct {
    logic [3:0]  icode, ifun;
    logic [63:0] a, b, c, exp;
  } evec_t;

  fvec_t fv [4];
  evec_t ev [10];
  logic [7:0] prog [10];

  initial begin
    rst = 1'b1;
    imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0; f_pc = '0;
    e_icode = '0; e_ifun = '0; e_valA = '0; e_valB = '0; e_valC = '0; set_cc = 1'b0;
    m_icode = '0; m_valA = '0; m_valE = '0; m_valP = '0;

    fv[0] = '{64'h00, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10, 1'b0};
    fv[1] = '{64'h20, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h21, 1'b1};
    fv[2] = '{64'h40, 4'h6, 4'h1, 4'h2, 4'h3, 64'd0, 64'h42, 1'b0};
    fv[3] = '{64'h50, 4'h7, 4'h0, 4'hF, 4'hF, 64'h12345678, 64'h59, 1'b0};

    ev[0] = '{4'h2, 4'h0, 64'h1234, 64'h9, 64'h0, 64'h1234};
    ev[1] = '{4'h3, 4'h0, 64'h1, 64'h2, 64'hABC, 64'hABC};
    ev[2] = '{4'h4, 4'h0, 64'h0, 64'h100, 64'h10, 64'h110};
    ev[3] = '{4'h5, 4'h0, 64'h0, 64'h8, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0};
    ev[4] = '{4'h6, 4'h1, 64'h5, 64'h3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE};
    ev[5] = '{4'h6, 4'h2, 64'hFF00, 64'hF0F0, 64'h0, 64'hF000};
    ev[6] = '{4'h6, 4'h3, 64'hFF00, 64'hF0F0, 64'h0, 64'h0FF0};
    ev[7] = '{4'h8, 4'h0, 64'h0, 64'h200, 64'h0, 64'h1F8};
    ev[8] = '{4'hB, 4'h0, 64'h0, 64'h200, 64'h0, 64'h208};
    ev[9] = '{4'h1, 4'h0, 64'h7, 64'h7, 64'h7, 64'h0};

    #2;
    flags("reset", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Program image
    prog = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 10; i++) load(64'(i), prog[i]);
    load(64'h20, 8'h00);
    load(64'h30, 8'hC0);
    load(64'h31, 8'h00);
    load(64'h40, 8'h61);
    load(64'h41, 8'h23);
    prog = '{8'h70, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 9; i++) load(64'h50 + 64'(i), prog[i]);
    load(64'(IMEM_BYTES - 5), 8'h30);
    load(64'(IMEM_BYTES), 8'h00);   // out of range, ignored

    for (int i = 0; i < 4; i++) begin
      f_pc = fv[i].pc;
      #1;
      chk($sformatf("f%0d_icode", i), 64'(f_icode), 64'(fv[i].icode));
      chk($sformatf("f%0d_ifun", i), 64'(f_ifun), 64'(fv[i].ifun));
      chk($sformatf("f%0d_rA", i), 64'(f_rA), 64'(fv[i].ra));
      chk($sformatf("f%0d_rB", i), 64'(f_rB), 64'(fv[i].rb));
      chk($sformatf("f%0d_valC", i), f_valC, fv[i].valc);
      chk($sformatf("f%0d_valP", i), f_valP, fv[i].valp);
      chk($sformatf("f%0d_valid", i), 64'(instr_valid), 64'd1);
      chk($sformatf("f%0d_ierr", i), 64'(imem_error), 64'd0);
      chk($sformatf("f%0d_hlt", i), 64'(hlt), 64'(fv[i].hlt));
    end

    f_pc = 64'h30; #1;
    chk("c0_valid", 64'(instr_valid), 64'd0);
    f_pc = 64'(IMEM_BYTES - 5); #1;
    chk("tail_ierr", 64'(imem_error), 64'd1);
    chk("tail_icode", 64'(f_icode), 64'd1);
    chk("tail_ifun", 64'(f_ifun), 64'd0);
    chk("tail_hlt", 64'(hlt), 64'd0);
    f_pc = 64'(IMEM_BYTES - 10); #1;
    chk("fit_ierr", 64'(imem_error), 64'd0);

    for (int i = 0; i < 10; i++) begin
      exec(ev[i].icode, ev[i].ifun, ev[i].a, ev[i].b, ev[i].c, 1'b0);
      chk($sformatf("alu%0d_valE", i), e_valE, ev[i].exp);
    end
    tick();
    flags("no_cc", 1'b1, 1'b0, 1'b0);

    // Signed add overflow
    exec(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    chk("add_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    flags("add", 1'b0, 1'b1, 1'b1);
    exec(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b0);
    tick();
    flags("add_nocc", 1'b0, 1'b1, 1'b1);

    exec(4'h6, 4'h1, 64'd5, 64'd5, 64'h0, 1'b1);
    chk("sub_valE", e_valE, 64'd0);
    chk("sub_flags_pending", 64'(zf), 64'd0);
    tick();
    flags("sub", 1'b1, 1'b0, 1'b0);
    exec(4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 1'b1);
    chk("je", 64'(e_cnd), 64'd1);
    exec(4'h7, 4'h4, 64'h0, 64'h0, 64'h0, 1'b1);
    chk("jne", 64'(e_cnd), 64'd0);
    exec(4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 1'b1);
    chk("jle", 64'(e_cnd), 64'd1);
    exec(4'h7, 4'h6, 64'h0, 64'h0, 64'h0, 1'b1);
    chk("jg", 64'(e_cnd), 64'd0);

    // Signed sub overflow: MIN - 1
    exec(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'h0, 1'b1);
    chk("subo_valE", e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
    tick();
    flags("subo", 1'b0, 1'b0, 1'b1);
    exec(4'h2, 4'h2, 64'h0, 64'h0, 64'h0, 1'b0);
    chk("cmovl", 64'(e_cnd), 64'd1);
    exec(4'h7, 4'h5, 64'h0, 64'h0, 64'h0, 1'b0);
    chk("jge", 64'(e_cnd), 64'd0);
    exec(4'h2, 4'h0, 64'h0, 64'h0, 64'h0, 1'b0);
    chk("rrmov", 64'(e_cnd), 64'd1);
    exec(4'h3, 4'h0, 64'h0, 64'h0, 64'h0, 1'b0);
    chk("irmov_cnd", 64'(e_cnd), 64'd0);

    // Data memory
    mem(4'h4, 64'h1122334455667788, 64'h40, 64'h0);
    chk("rmmov_err", 64'(dmem_error), 64'd0);
    chk("rmmov_valM", m_valM, 64'd0);
    tick();
    mem(4'h5, 64'h0, 64'h40, 64'h0);
    chk("mrmov_valM", m_valM, 64'h1122334455667788);
    chk("mrmov_byte0", 64'(m_valM[7:0]), 64'h88);
    mem(4'h8, 64'h0, 64'h100, 64'h55);
    tick();
    mem(4'h9, 64'h100, 64'h0, 64'h0);
    chk("ret_valM", m_valM, 64'h55);
    mem(4'h4, 64'h0102030405060708, 64'(DMEM_BYTES - 8), 64'h0);
    chk("edge_err", 64'(dmem_error), 64'd0);
    tick();
    mem(4'h4, 64'hDEAD, 64'(DMEM_BYTES - 4), 64'h0);
    chk("oob_err", 64'(dmem_error), 64'd1);
    tick();
    mem(4'h5, 64'h0, 64'(DMEM_BYTES - 8), 64'h0);
    chk("oob_nowrite", m_valM, 64'h0102030405060708);
    mem(4'h5, 64'h0, 64'(DMEM_BYTES - 4), 64'h0);
    chk("oob_rd_err", 64'(dmem_error), 64'd1);
    chk("oob_rd_valM", m_valM, 64'd0);

    // Async reset between edges
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    flags("midrst", 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
